// File: rtl/reg_file_wb.sv
// reg_file_wb: write-back side of the pipeline. Holds the 32-entry
// architectural register file (x0 hardwired to zero). It commits MEM/WB
// write-backs and serves two write-first bypassed read ports to ID.
// A per-register in-flight counter scoreboard stalls ID on RAW hazards
// that the same-cycle bypass cannot cover.
//
// Ports:
//   clk, rst_n          clock; asynchronous reset, ACTIVE-HIGH despite the name
//   RF_wd_WB/wR_WB/RF_we_WB  write-back data / index / enable
//   rR1/rR2, use1/use2  ID read indices and "operand actually used" flags
//   issue_valid/we/wR   instruction leaving ID and its destination
//   kill_we/kill_wR     destination of a squashed in-flight instruction
//   rD1/rD2             combinational read data
//   hazard              combinational ID stall
//   sb_err              sticky scoreboard underflow/overflow flag
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] RF_wd_WB,
    input  logic [ADDR_W-1:0] wR_WB,
    input  logic              RF_we_WB,
    input  logic [ADDR_W-1:0] rR1,
    input  logic [ADDR_W-1:0] rR2,
    input  logic              use1,
    input  logic              use2,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_wR,
    input  logic              kill_we,
    input  logic [ADDR_W-1:0] kill_wR,
    output logic [DATA_W-1:0] rD1,
    output logic [DATA_W-1:0] rD2,
    output logic              hazard,
    output logic              sb_err
);
    localparam int NREG = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic              sb_err_q, sb_err_d;
    logic [NREG-1:0]   wb_hit, busy;
    logic              hazard_c, issue_fire;
    logic [DATA_W-1:0] rd1_c, rd2_c;
    logic              inc;
    logic [CNT_W:0]    dec, sum, nxt;

    // A producer writing back this cycle is covered by the bypass, so it
    // only stalls a reader if another producer of the same register remains.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wb_hit[r] = RF_we_WB && (wR_WB == ADDR_W'(r)) && (r != 0);
            busy[r]   = cnt_q[r] > CNT_W'(wb_hit[r]);
        end
    end

    always_comb begin
        hazard_c = issue_valid &&
                   ((use1 && rR1 != '0 && busy[rR1]) ||
                    (use2 && rR2 != '0 && busy[rR2]) ||
                    (issue_we && issue_wR != '0 && cnt_q[issue_wR] == CNT_MAX &&
                     !wb_hit[issue_wR]));
        if (rst_n) hazard_c = 1'b0;
    end

    assign issue_fire = issue_valid && !hazard_c && issue_we && issue_wR != '0;

    // Write-first read ports; entry 0 is never written so it reads zero,
    // but it is forced here too so a write-back to x0 is never bypassed.
    always_comb begin
        rd1_c = regs_q[rR1];
        if (rst_n || rR1 == '0)               rd1_c = '0;
        else if (RF_we_WB && wR_WB == rR1)    rd1_c = RF_wd_WB;
        rd2_c = regs_q[rR2];
        if (rst_n || rR2 == '0)               rd2_c = '0;
        else if (RF_we_WB && wR_WB == rR2)    rd2_c = RF_wd_WB;
    end

    // Counter next state: one extra bit of headroom so both saturation
    // directions can be detected before truncating back to CNT_W.
    always_comb begin
        sb_err_d = sb_err_q;
        inc      = 1'b0;
        dec      = '0;
        sum      = '0;
        nxt      = '0;
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            inc = issue_fire && (issue_wR == ADDR_W'(r));
            dec = (CNT_W+1)'(wb_hit[r]) +
                  (CNT_W+1)'(kill_we && (kill_wR == ADDR_W'(r)));
            sum = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc);
            if (dec > sum) begin
                cnt_d[r] = '0;
                sb_err_d = 1'b1;
            end else begin
                nxt = sum - dec;
                if (nxt > {1'b0, CNT_MAX}) begin
                    cnt_d[r] = CNT_MAX;
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = nxt[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else if (RF_we_WB && wR_WB != '0) begin
            regs_q[wR_WB] <= RF_wd_WB;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            sb_err_q <= sb_err_d;
        end
    end

    assign rD1    = rd1_c;
    assign rD2    = rd2_c;
    assign hazard = hazard_c;
    assign sb_err = sb_err_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: the driver applies inputs just after each
// rising edge, predicts outputs from an array/integer reference model and
// queues them; the monitor pops and compares at each falling edge.
module tb_reg_file_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] RF_wd_WB;
    logic [4:0]  wR_WB, rR1, rR2, issue_wR, kill_wR;
    logic        RF_we_WB, use1, use2, issue_valid, issue_we, kill_we;
    logic [31:0] rD1, rD2;
    logic        hazard, sb_err;

    always #5 clk = ~clk;

    reg_file_wb dut (
        .clk(clk), .rst_n(rst),
        .RF_wd_WB(RF_wd_WB), .wR_WB(wR_WB), .RF_we_WB(RF_we_WB),
        .rR1(rR1), .rR2(rR2), .use1(use1), .use2(use2),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_wR(issue_wR),
        .kill_we(kill_we), .kill_wR(kill_wR),
        .rD1(rD1), .rD2(rD2), .hazard(hazard), .sb_err(sb_err)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        hz;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  infl[$];
    int          total = 0;
    int          bad   = 0;

    // Reference model state
    logic [31:0] m_regs[32];
    int          m_cnt[32];
    bit          m_err;
    bit          m_fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rD1", rD1, e.rd1);
                chk("rD2", rD2, e.rd2);
                chk("hazard", {31'd0, hazard}, {31'd0, e.hz});
                chk("sb_err", {31'd0, sb_err}, {31'd0, e.err});
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (RF_we_WB && wR_WB == idx) return RF_wd_WB;
        return m_regs[idx];
    endfunction

    // 1 if a write-back to register idx lands this cycle (bypass covers it)
    function automatic int m_cover(input logic [4:0] idx);
        return (RF_we_WB && wR_WB == idx && idx != 0) ? 1 : 0;
    endfunction

    task automatic clr();
        RF_we_WB = 0; wR_WB = 0; RF_wd_WB = 0;
        rR1 = 0; rR2 = 0; use1 = 0; use2 = 0;
        issue_valid = 0; issue_we = 0; issue_wR = 0;
        kill_we = 0; kill_wR = 0;
    endtask

    // Predict this cycle's outputs, queue them, advance the model across the
    // coming rising edge, then move to just after that edge.
    task automatic step();
        exp_t e;
        bit   hz;
        int   nc;
        if (rst) begin
            e = '{32'd0, 32'd0, 1'b0, 1'b0};
            m_fire = 0;
        end else begin
            hz = 0;
            if (issue_valid) begin
                if (use1 && rR1 != 0 && m_cnt[rR1] > m_cover(rR1)) hz = 1;
                if (use2 && rR2 != 0 && m_cnt[rR2] > m_cover(rR2)) hz = 1;
                if (issue_we && issue_wR != 0 && m_cnt[issue_wR] == 3 &&
                    m_cover(issue_wR) == 0) hz = 1;
            end
            e.rd1 = m_read(rR1);
            e.rd2 = m_read(rR2);
            e.hz  = hz;
            e.err = m_err;
            m_fire = issue_valid && !hz && issue_we && issue_wR != 0;
        end
        exp_q.push_back(e);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_cnt[r] = 0; end
            m_err = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                nc = m_cnt[r] + ((m_fire && issue_wR == r) ? 1 : 0)
                     - m_cover(5'(r)) - ((kill_we && kill_wR == r) ? 1 : 0);
                if (nc < 0) begin nc = 0; m_err = 1; end
                else if (nc > 3) begin nc = 3; m_err = 1; end
                m_cnt[r] = nc;
            end
            if (RF_we_WB && wR_WB != 0) m_regs[wR_WB] = RF_wd_WB;
        end
        @(posedge clk); #1;
    endtask

    task automatic wb(input logic [4:0] idx, input logic [31:0] d);
        RF_we_WB = 1; wR_WB = idx; RF_wd_WB = d;
    endtask

    task automatic iss(input logic [4:0] idx);
        issue_valid = 1; issue_we = 1; issue_wR = idx;
    endtask

    initial begin
        clr();
        @(posedge clk); #1;
        // reset, then read
        step(); step();
        rst = 0;
        rR1 = 5; rR2 = 0; step();
        // write / bypass / readback / x0
        clr(); wb(7, 32'hDEADBEEF); rR1 = 7; step();
        clr(); rR1 = 7; step();
        clr(); wb(0, 32'h1234); rR1 = 0; rR2 = 0; step();
        clr(); rR2 = 0; rR1 = 7; step();
        // RAW stall on x3
        clr(); iss(3); step();
        clr(); issue_valid = 1; use1 = 1; rR1 = 3; step(); step();
        wb(3, 32'hA5A5_0003); step();
        clr(); issue_valid = 1; use1 = 1; rR1 = 3; step();
        // double producer on x4, checked on port 2
        clr(); iss(4); step(); step();
        clr(); issue_valid = 1; use2 = 1; rR2 = 4; wb(4, 32'h44); step();
        wb(4, 32'h45); step();
        clr(); issue_valid = 1; use2 = 1; rR2 = 4; step();
        // saturation on x9
        clr(); iss(9); step(); step(); step();
        step();                              // fourth issue stalls
        wb(9, 32'h99); step();               // covered by WB, nets out
        clr(); iss(9); step();               // still at max -> stall
        clr(); wb(9, 1); step(); wb(9, 2); step(); wb(9, 3); step();
        clr(); issue_valid = 1; use1 = 1; rR1 = 9; step();
        // flush and sticky error
        clr(); iss(6); step();
        clr(); kill_we = 1; kill_wR = 6; step();
        clr(); issue_valid = 1; use1 = 1; rR1 = 6; step();
        clr(); kill_we = 1; kill_wR = 6; step();
        clr(); step(); step();
        rst = 1; step(); rst = 0; clr(); step();

        // realistic pipeline: write-backs and kills come from issued producers
        for (int i = 0; i < 400; i++) begin
            clr();
            rR1 = 5'($urandom_range(0, 7)); rR2 = 5'($urandom_range(0, 7));
            use1 = 1'($urandom); use2 = 1'($urandom);
            issue_valid = ($urandom % 4) != 0; issue_we = 1'($urandom);
            issue_wR = 5'($urandom_range(0, 7));
            if (infl.size() > 0 && ($urandom % 2) == 1)
                wb(infl.pop_front(), $urandom);
            if (infl.size() > 0 && ($urandom % 12) == 0) begin
                kill_we = 1; kill_wR = infl.pop_back();
            end
            step();
            if (m_fire) infl.push_back(issue_wR);
        end
        // unconstrained traffic with occasional mid-run resets
        for (int i = 0; i < 400; i++) begin
            clr();
            rst = ($urandom % 60) == 0;
            rR1 = 5'($urandom); rR2 = 5'($urandom);
            use1 = 1'($urandom); use2 = 1'($urandom);
            issue_valid = 1'($urandom); issue_we = 1'($urandom);
            issue_wR = 5'($urandom_range(0, 7));
            if (($urandom % 3) == 0) wb(5'($urandom_range(0, 7)), $urandom);
            if (($urandom % 10) == 0) begin
                kill_we = 1; kill_wR = 5'($urandom_range(0, 7));
            end
            step();
        end
        rst = 0; clr(); step();
        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
